// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: status codes, sampler state encoding, default widths.
package iagc_pkg;

    localparam int unsigned IAGC_DATA_SIZE_DEFAULT = 14;

    localparam logic [3:0] IAGC_STATUS_RESET = 4'b0000;
    localparam logic [3:0] IAGC_STATUS_INIT  = 4'b0001;

    localparam logic [1:0] SMP_IDLE  = 2'd0;
    localparam logic [1:0] SMP_WAIT  = 2'd1;
    localparam logic [1:0] SMP_ACCUM = 2'd2;

endpackage

// File: rtl/iagc_sample_averager.sv
// One sampler channel: accumulates 2^AVG_LOG2 accepted words, exposes the
// floor average including the word currently presented, and flags full-scale
// input. IAGC_SAMPLER_OFFSET_BINARY_EN selects offset-binary input words.
module iagc_sample_averager
    import iagc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = IAGC_DATA_SIZE_DEFAULT,
    parameter int unsigned AVG_LOG2  = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic [DATA_SIZE-1:0] o_average,
    output logic                 o_last,
    output logic                 o_overrange
);

    localparam int unsigned ACC_SIZE = DATA_SIZE + AVG_LOG2;
    localparam int unsigned CNT_SIZE = AVG_LOG2 + 1;
    localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_SIZE-1:0] FULL_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] FULL_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic signed [DATA_SIZE-1:0] word;
    logic signed [ACC_SIZE-1:0]  acc_q, acc_d, sum;
    logic [CNT_SIZE-1:0]         cnt_q, cnt_d;
    logic                        ovr_q, ovr_d;
    logic                        full_scale;

`ifdef IAGC_SAMPLER_OFFSET_BINARY_EN
    assign word = {~i_data[DATA_SIZE-1], i_data[DATA_SIZE-2:0]};
`else
    assign word = i_data;
`endif

    // both operands signed, so the word is sign-extended into the accumulator
    assign sum         = acc_q + word;
    assign o_average   = DATA_SIZE'(sum >>> AVG_LOG2);
    assign o_last      = (cnt_q == CNT_LAST);
    assign full_scale  = (word == FULL_POS) || (word == FULL_NEG);
    assign o_overrange = ovr_q;

    // next accumulator / count / sticky overrange
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (i_accept) begin
            if (full_scale) begin
                ovr_d = 1'b1;
            end
            if (o_last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // channel state registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

endmodule

// File: rtl/iagc_sampler.sv
// IAGC sampler: waits a programmable period, averages 2^AVG_LOG2 valid ADC
// words per channel, then strobes the averaged reference/error words to the
// phase detector. Status RESET soft-clears in step with the detector.
// IAGC_SAMPLER_OFFSET_BINARY_EN selects offset-binary ADC inputs.
module iagc_sampler
    import iagc_pkg::*;
#(
    parameter int unsigned IAGC_STATUS_SIZE  = 4,
    parameter int unsigned SAMPLER_DATA_SIZE = IAGC_DATA_SIZE_DEFAULT,
    parameter int unsigned PERIOD_SIZE       = 16,
    parameter int unsigned AVG_LOG2          = 2
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0]  i_iagc_status,
    input  logic [PERIOD_SIZE-1:0]       i_sample_period,
    input  logic                         i_adc_valid,
    input  logic [SAMPLER_DATA_SIZE-1:0] i_adc_reference,
    input  logic [SAMPLER_DATA_SIZE-1:0] i_adc_error,
    output logic                         o_sample,
    output logic [SAMPLER_DATA_SIZE-1:0] o_reference,
    output logic [SAMPLER_DATA_SIZE-1:0] o_error,
    output logic [PERIOD_SIZE-1:0]       o_sample_count,
    output logic                         o_overrange
);

    logic [1:0]                   state_q, state_d;
    logic [PERIOD_SIZE-1:0]       period_cnt_q, period_cnt_d;
    logic [PERIOD_SIZE-1:0]       period_eff;
    logic                         sample_q, sample_d;
    logic [PERIOD_SIZE-1:0]       count_q, count_d;
    logic [SAMPLER_DATA_SIZE-1:0] ref_q, ref_d, err_q, err_d;
    logic [SAMPLER_DATA_SIZE-1:0] ref_avg, err_avg;
    logic                         ref_last, err_last, ref_ovr, err_ovr;
    logic                         soft_clear, wait_done, accept, final_word;

    assign soft_clear = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_RESET));
    assign period_eff = (i_sample_period == '0) ? PERIOD_SIZE'(1) : i_sample_period;
    // one extra bit so counter+1 cannot wrap before the compare
    assign wait_done  = ((PERIOD_SIZE+1)'(period_cnt_q) + (PERIOD_SIZE+1)'(1))
                        >= (PERIOD_SIZE+1)'(period_eff);
    assign accept     = (state_q == SMP_ACCUM) && i_adc_valid && !soft_clear;
    assign final_word = accept && ref_last && err_last;

    iagc_sample_averager #(
        .DATA_SIZE (SAMPLER_DATA_SIZE),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg_reference (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (soft_clear),
        .i_accept    (accept),
        .i_data      (i_adc_reference),
        .o_average   (ref_avg),
        .o_last      (ref_last),
        .o_overrange (ref_ovr)
    );

    iagc_sample_averager #(
        .DATA_SIZE (SAMPLER_DATA_SIZE),
        .AVG_LOG2  (AVG_LOG2)
    ) u_avg_error (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (soft_clear),
        .i_accept    (accept),
        .i_data      (i_adc_error),
        .o_average   (err_avg),
        .o_last      (err_last),
        .o_overrange (err_ovr)
    );

    // sequencing: IDLE -> WAIT (period) -> ACCUM (averaging) -> strobe -> WAIT
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        sample_d     = 1'b0;
        count_d      = count_q;
        ref_d        = ref_q;
        err_d        = err_q;
        if (soft_clear) begin
            state_d      = SMP_IDLE;
            period_cnt_d = '0;
            count_d      = '0;
        end else begin
            case (state_q)
                SMP_IDLE: begin
                    state_d      = SMP_WAIT;
                    period_cnt_d = '0;
                end
                SMP_WAIT: begin
                    period_cnt_d = period_cnt_q + 1'b1;
                    if (wait_done) begin
                        state_d = SMP_ACCUM;
                    end
                end
                SMP_ACCUM: begin
                    if (final_word) begin
                        state_d      = SMP_WAIT;
                        period_cnt_d = '0;
                        sample_d     = 1'b1;
                        ref_d        = ref_avg;
                        err_d        = err_avg;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d      = SMP_IDLE;
                    period_cnt_d = '0;
                end
            endcase
        end
    end

    // control and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= SMP_IDLE;
            period_cnt_q <= '0;
            sample_q     <= 1'b0;
            count_q      <= '0;
            ref_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            sample_q     <= sample_d;
            count_q      <= count_d;
            ref_q        <= ref_d;
            err_q        <= err_d;
        end
    end

    assign o_sample       = sample_q;
    assign o_reference    = ref_q;
    assign o_error        = err_q;
    assign o_sample_count = count_q;
    assign o_overrange    = ref_ovr | err_ovr;

endmodule

// File: tb/tb_iagc_sampler.sv
// Directed bench for iagc_sampler; expected strobes come from a scoreboard
// queue filled as the final word of each sample is driven.
module tb_iagc_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  status;
    logic [15:0] period;
    logic        valid;
    logic [13:0] aref, aerr;

    logic        o_sample, o_ovr;
    logic [13:0] o_ref, o_err;
    logic [15:0] o_cnt;

    logic        s_sample, s_ovr;
    logic [13:0] s_ref, s_err;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    iagc_sampler #(
        .IAGC_STATUS_SIZE  (4),
        .SAMPLER_DATA_SIZE (14),
        .PERIOD_SIZE       (16),
        .AVG_LOG2          (2)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_iagc_status   (status),
        .i_sample_period (period),
        .i_adc_valid     (valid),
        .i_adc_reference (aref),
        .i_adc_error     (aerr),
        .o_sample        (o_sample),
        .o_reference     (o_ref),
        .o_error         (o_err),
        .o_sample_count  (o_cnt),
        .o_overrange     (o_ovr)
    );

    // narrow-counter instance so saturation is reachable in a short run
    iagc_sampler #(
        .IAGC_STATUS_SIZE  (4),
        .SAMPLER_DATA_SIZE (14),
        .PERIOD_SIZE       (4),
        .AVG_LOG2          (2)
    ) dut_sat (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_iagc_status   (status),
        .i_sample_period (4'd0),
        .i_adc_valid     (valid),
        .i_adc_reference (aref),
        .i_adc_error     (aerr),
        .o_sample        (s_sample),
        .o_reference     (s_ref),
        .o_error         (s_err),
        .o_sample_count  (s_cnt),
        .o_overrange     (s_ovr)
    );

    typedef struct {
        logic [13:0] r;
        logic [13:0] e;
        logic [15:0] c;
        logic        o;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0;
    int          nerr = 0;
    int          sr = 0, se = 0, nw = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_ovr = 1'b0;

    function automatic logic [13:0] enc(input int v);
        logic [13:0] w;
        w = 14'(v);
`ifdef IAGC_SAMPLER_OFFSET_BINARY_EN
        w[13] = ~w[13];
`endif
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one cycle; acc marks a word the bench knows will be accepted
    task automatic step(input logic v, input int r, input int e, input bit acc);
        exp_t x;
        valid = v;
        aref  = enc(r);
        aerr  = enc(e);
        if (acc) begin
            sr += r;
            se += e;
            nw++;
            if (r == 8191 || r == -8192 || e == 8191 || e == -8192) exp_ovr = 1'b1;
            if (nw == 4) begin
                if (exp_cnt != 16'hFFFF) exp_cnt++;
                x.r = 14'(sr >>> 2);
                x.e = 14'(se >>> 2);
                x.c = exp_cnt;
                x.o = exp_ovr;
                sbq.push_back(x);
                sr = 0; se = 0; nw = 0;
            end
        end
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("strobe", 32'(o_sample), 32'd1);
            chk("reference", 32'(o_ref), 32'(x.r));
            chk("error", 32'(o_err), 32'(x.e));
            chk("sample_count", 32'(o_cnt), 32'(x.c));
            chk("overrange", 32'(o_ovr), 32'(x.o));
        end else begin
            chk("no_strobe", 32'(o_sample), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; status = 4'b0000; period = 16'd3;
        valid = 1'b0; aref = '0; aerr = '0;
        idle(3);
        chk("rst_ref", 32'(o_ref), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_ovr", 32'(o_ovr), 32'd0);

        // basic averaging, period 3
        rst = 1'b0; status = 4'b0001;
        idle(6);
        step(1'b1, 100, -1, 1'b1);
        step(1'b1, 102, -2, 1'b1);
        step(1'b1, 104, -2, 1'b1);
        step(1'b1, 106, -2, 1'b1);
        idle(1);
        chk("hold_ref", 32'(o_ref), 32'd103);
        chk("hold_err", 32'(o_err), 32'h3FFE);

        // positive full scale sets sticky overrange
        idle(6);
        step(1'b1, 8191, 0, 1'b1);
        chk("ovr_set", 32'(o_ovr), 32'd1);
        step(1'b1, 0, 0, 1'b1);
        step(1'b1, 0, 0, 1'b1);
        step(1'b1, 1, 0, 1'b1);

        // overrange persists; floor of negative average
        idle(6);
        step(1'b1, -4, 10, 1'b1);
        step(1'b1, -4, 20, 1'b1);
        step(1'b1, -4, 30, 1'b1);
        step(1'b1, -5, 40, 1'b1);

        // abort: soft clear in the cycle of the final word
        idle(6);
        step(1'b1, 1, 1, 1'b1);
        step(1'b1, 1, 1, 1'b1);
        step(1'b1, 1, 1, 1'b1);
        status = 4'b0000;
        sr = 0; se = 0; nw = 0; exp_cnt = '0; exp_ovr = 1'b0;
        step(1'b1, 1, 1, 1'b0);
        chk("abort_ref", 32'(o_ref), 32'h3FFB);
        chk("abort_err", 32'(o_err), 32'd25);
        chk("abort_cnt", 32'(o_cnt), 32'd0);
        chk("abort_ovr", 32'(o_ovr), 32'd0);

        // restart: IDLE, 3 WAIT cycles, then 4 words (valid during WAIT ignored)
        status = 4'b0001;
        for (int i = 1; i <= 8; i++) step(1'b1, 20, -3, i >= 5);

        // period 0, continuous valid: one WAIT cycle then four words
        period = 16'd0;
        for (int i = 1; i <= 100; i++) step(1'b1, 50, -7, (i % 5) != 1);
        chk("final_cnt", 32'(o_cnt), 32'd21);
        chk("sat_cnt", 32'(s_cnt), 32'hF);

`ifdef IAGC_SAMPLER_OFFSET_BINARY_EN
        // raw offset-binary 0x2064 is +100
        period = 16'd3;
        idle(6);
        valid = 1'b1; aref = 14'h2064; aerr = 14'h2064;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ob_no_strobe", 32'(o_sample), 32'd0);
        end
        @(posedge clk); #1;
        chk("ob_strobe", 32'(o_sample), 32'd1);
        chk("ob_ref", 32'(o_ref), 32'd100);
        chk("ob_err", 32'(o_err), 32'd100);
        valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iagc_sampler.md
Name: iagc_sampler

Overview:
- Producer side of the sample interface that feeds the phase detector. It emits the sample strobe and the held reference/error words that the detector consumes.
- Takes raw ADC reference/error streams and waits a programmable interval between sample points. At each point it averages 2^AVG_LOG2 valid ADC words per channel, then issues a one-cycle sample strobe with the averaged two's-complement words.
- Follows the IAGC status bus, so a status RESET code aborts and clears it in step with the detector.

Parameters:
- IAGC_STATUS_SIZE, 4, width of IAGC status bus
- SAMPLER_DATA_SIZE, 14, width of ADC and output data words; MSB is sign
- PERIOD_SIZE, 16, width of sample-period input and strobe counter
- AVG_LOG2, 2, log2 of valid ADC words averaged per sample (0 = no averaging)

Ports:
- i_clock  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_iagc_status  in  IAGC_STATUS_SIZE  IAGC status; 4'b0000 = RESET code
- i_sample_period  in  PERIOD_SIZE  idle clocks between sample points; 0 treated as 1
- i_adc_valid  in  1  ADC words valid this cycle
- i_adc_reference  in  SAMPLER_DATA_SIZE  raw reference ADC word
- i_adc_error  in  SAMPLER_DATA_SIZE  raw error ADC word
- o_sample  out  1  one-cycle strobe; o_reference/o_error valid in the same cycle
- o_reference  out  SAMPLER_DATA_SIZE  averaged reference, two's complement, held between strobes
- o_error  out  SAMPLER_DATA_SIZE  averaged error, two's complement, held between strobes
- o_sample_count  out  PERIOD_SIZE  strobes since last clear, saturating at all-ones
- o_overrange  out  1  sticky: a full-scale ADC word was accumulated

Behaviour:
- Reset (i_reset=1): state IDLE; all counters and accumulators 0; all outputs 0.
- Soft clear (status==RESET, i_reset=0):
  - forces IDLE and clears counters, accumulators, o_sample_count and o_overrange;
  - o_sample=0; o_reference/o_error hold their last values.
- State IDLE: leave to WAIT on the first cycle status!=RESET; period counter loads 0.
- State WAIT:
  - period counter increments every clock;
  - when counter+1 >= max(i_sample_period,1), go to ACCUM next cycle;
  - i_sample_period is compared live, so a mid-WAIT change takes effect immediately.
- State ACCUM:
  - each cycle with i_adc_valid=1, add the sign-extended words to accumulators of width SAMPLER_DATA_SIZE+AVG_LOG2, and increment the valid count;
  - cycles without valid are ignored (no timeout).
- On the cycle the 2^AVG_LOG2-th valid word is accepted:
  - the averaged value (accumulator including current word, arithmetic shift right by AVG_LOG2, floor) registers into o_reference/o_error;
  - o_sample registers 1 and is visible the next cycle, for exactly one cycle;
  - o_sample_count increments in the same cycle as o_sample;
  - state returns to WAIT with counter 0 and accumulators cleared.
- Latency and spacing:
  - o_sample is 1 cycle after the last accepted ADC word;
  - minimum strobe spacing is max(period,1) + 2^AVG_LOG2 cycles.
- Overrange:
  - any accepted word equal to the most positive (0x1FFF) or most negative (0x2000) value, on either channel, sets o_overrange;
  - it stays set until reset or soft clear.
- Sum cannot overflow: accumulator width covers the full range.
- Simultaneous events:
  - i_reset has priority over soft clear, and soft clear over everything else;
  - status going to RESET in the same cycle as the final valid word aborts: no strobe and no output update.
- Status codes other than RESET do not affect operation.

Optional Feature:
- Macro IAGC_SAMPLER_OFFSET_BINARY_EN.
- Defined: ADC inputs are offset binary. Each word's MSB is inverted before accumulation and overrange checks (full scale is then raw 0x3FFF / 0x0000).
- Undefined: inputs are already two's complement and used as-is.
- Output format is two's complement in both cases.

Decomposition:
- Shared package iagc_pkg:
  - IAGC status codes (IAGC_STATUS_RESET=4'b0000, IAGC_STATUS_INIT=4'b0001);
  - sampler state encoding (IDLE/WAIT/ACCUM);
  - default data width 14.
- One sub-module, iagc_sample_averager:
  - one channel: accumulator, valid count, shift, overrange detect;
  - instantiated twice (reference, error); the top owns the FSM and strobe.

Test Plan:
- Reset, then status 0001, period 3, AVG_LOG2=2, ref 100,102,104,106 valid back-to-back -> o_sample one cycle after the 4th word, o_reference=103, o_sample_count=1.
- Error words -1,-2,-2,-2 -> o_error=14'h3FFE (-2, floor of -1.75), o_overrange=0.
- Ref word 0x1FFF among the four -> o_overrange=1 after acceptance; stays 1 across later strobes until status 0000 clears it.
- Status to 0000 after 3 of 4 valid words, then back to 0001 -> no strobe; next strobe needs a full period plus 4 new words; o_reference keeps its prior value.
- Period 0 with continuous valid -> strobes exactly every 5 cycles; o_sample_count saturates at 16'hFFFF when forced near full.
- With IAGC_SAMPLER_OFFSET_BINARY_EN defined, four raw words 0x2064 -> o_reference=100.
